// File: rtl/hicore_icb_err_slave_if.sv
// ICB command/response bundle for the default (error) slave; no latency, pure wiring.
// Backpressure: cmd_ready from slave, rsp_ready from master.
interface hicore_icb_err_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic            icb_rsp_err;
  logic [DW-1:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/hicore_icb_err_slave.sv
// ICB default slave: answers every command in order after LAT cycles (min) with a fixed err/rdata policy.
// Up to DEPTH outstanding; cmd_ready drops only when full and the head is not popping this cycle.
module hicore_icb_err_slave #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            DEPTH     = 2,
  parameter int            LAT       = 1,
  parameter int            ERR_MODE  = 0,
  parameter logic [DW-1:0] RDATA_VAL = '0,
  parameter int            CW        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hicore_icb_err_slave_if.slave icb,
  output logic [CW-1:0]        err_cnt,
  input  logic                 err_cnt_clr
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          ent_err_q [DEPTH];
  logic          ent_err_d [DEPTH];
  logic          ent_rd_q  [DEPTH];
  logic          ent_rd_d  [DEPTH];
  logic [3:0]    ent_cnt_q [DEPTH];
  logic [3:0]    ent_cnt_d [DEPTH];
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  logic [IW-1:0] wr_idx, rd_idx;
  logic          empty, full, push, pop, acc_err;
  logic          head_err, head_rd;
  logic [3:0]    head_cnt;
  logic          unused_ok;

  // Wrap is compare-and-reset so non-power-of-two depths never visit a dead slot.
  function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
    logic [IW:0] r;
    r = p;
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      r[IW-1:0] = '0;
      r[IW]     = ~p[IW];
    end else begin
      r[IW-1:0] = p[IW-1:0] + 1'b1;
    end
    return r;
  endfunction

  assign wr_idx   = wr_ptr_q[IW-1:0];
  assign rd_idx   = rd_ptr_q[IW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_idx == rd_idx) && (wr_ptr_q[IW] != rd_ptr_q[IW]);
  assign head_err = ent_err_q[rd_idx];
  assign head_rd  = ent_rd_q[rd_idx];
  assign head_cnt = ent_cnt_q[rd_idx];

  assign icb.icb_rsp_valid = !empty && (head_cnt == 4'd0);
  assign icb.icb_rsp_err   = icb.icb_rsp_valid && head_err;
  assign icb.icb_rsp_rdata = (icb.icb_rsp_valid && head_rd && !head_err) ? RDATA_VAL : '0;
  assign pop               = icb.icb_rsp_valid && icb.icb_rsp_ready;
  assign icb.icb_cmd_ready = !full || pop;
  assign push              = icb.icb_cmd_valid && icb.icb_cmd_ready;
  assign err_cnt           = err_cnt_q;

  assign unused_ok = ^{icb.icb_cmd_wdata, icb.icb_cmd_wmask, icb.icb_cmd_addr};

  always_comb begin
    acc_err = 1'b0;
    case (ERR_MODE)
      1:       acc_err = 1'b1;
      2:       acc_err = !icb.icb_cmd_read;
      3:       acc_err = (icb.icb_cmd_addr[1:0] != 2'b00);
      default: acc_err = 1'b0;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    // Free slots also count down; harmless since a push reloads the counter.
    for (int i = 0; i < DEPTH; i++) begin
      ent_err_d[i] = ent_err_q[i];
      ent_rd_d[i]  = ent_rd_q[i];
      ent_cnt_d[i] = (ent_cnt_q[i] != 4'd0) ? ent_cnt_q[i] - 4'd1 : 4'd0;
    end
    if (push) begin
      ent_err_d[wr_idx] = acc_err;
      ent_rd_d[wr_idx]  = icb.icb_cmd_read;
      ent_cnt_d[wr_idx] = 4'(LAT - 1);
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (err_cnt_clr) begin
      err_cnt_d = '0;
    end else if (pop && head_err && (err_cnt_q != {CW{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_err_q[i] <= 1'b0;
        ent_rd_q[i]  <= 1'b0;
        ent_cnt_q[i] <= 4'd0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_err_q[i] <= ent_err_d[i];
        ent_rd_q[i]  <= ent_rd_d[i];
        ent_cnt_q[i] <= ent_cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_hicore_icb_err_slave.sv
// Bench for hicore_icb_err_slave: three differently parameterised instances, directed stimulus,
// expected responses queued at command accept and compared by a negedge monitor.
module tb_hicore_icb_err_slave;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic        cv [3];
  logic        rd [3];
  logic        rr [3];
  logic        clr [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic        cr [3];
  logic        rv [3];
  logic        re [3];
  logic [31:0] rdt [3];
  logic [15:0] ec [3];
  logic [15:0] ec0, ec1;
  logic [1:0]  ec2;

  hicore_icb_err_slave_if #(.AW(32), .DW(32)) i0 ();
  hicore_icb_err_slave_if #(.AW(32), .DW(32)) i1 ();
  hicore_icb_err_slave_if #(.AW(32), .DW(32)) i2 ();

  hicore_icb_err_slave #(.AW(32), .DW(32), .DEPTH(2), .LAT(1), .ERR_MODE(0),
                         .RDATA_VAL(32'hDEAD_BEEF), .CW(16))
    u0 (.clk(clk), .rst_n(rst_n), .icb(i0), .err_cnt(ec0), .err_cnt_clr(clr[0]));
  hicore_icb_err_slave #(.AW(32), .DW(32), .DEPTH(4), .LAT(3), .ERR_MODE(2),
                         .RDATA_VAL(32'h1234_5678), .CW(16))
    u1 (.clk(clk), .rst_n(rst_n), .icb(i1), .err_cnt(ec1), .err_cnt_clr(clr[1]));
  hicore_icb_err_slave #(.AW(32), .DW(32), .DEPTH(3), .LAT(1), .ERR_MODE(3),
                         .RDATA_VAL(32'hCAFE_F00D), .CW(2))
    u2 (.clk(clk), .rst_n(rst_n), .icb(i2), .err_cnt(ec2), .err_cnt_clr(clr[2]));

  assign i0.icb_cmd_valid = cv[0]; assign i1.icb_cmd_valid = cv[1]; assign i2.icb_cmd_valid = cv[2];
  assign i0.icb_cmd_addr  = ad[0]; assign i1.icb_cmd_addr  = ad[1]; assign i2.icb_cmd_addr  = ad[2];
  assign i0.icb_cmd_read  = rd[0]; assign i1.icb_cmd_read  = rd[1]; assign i2.icb_cmd_read  = rd[2];
  assign i0.icb_cmd_wdata = wd[0]; assign i1.icb_cmd_wdata = wd[1]; assign i2.icb_cmd_wdata = wd[2];
  assign i0.icb_cmd_wmask = wd[0][3:0]; assign i1.icb_cmd_wmask = wd[1][3:0];
  assign i2.icb_cmd_wmask = wd[2][3:0];
  assign i0.icb_rsp_ready = rr[0]; assign i1.icb_rsp_ready = rr[1]; assign i2.icb_rsp_ready = rr[2];
  assign cr[0]  = i0.icb_cmd_ready; assign cr[1]  = i1.icb_cmd_ready; assign cr[2]  = i2.icb_cmd_ready;
  assign rv[0]  = i0.icb_rsp_valid; assign rv[1]  = i1.icb_rsp_valid; assign rv[2]  = i2.icb_rsp_valid;
  assign re[0]  = i0.icb_rsp_err;   assign re[1]  = i1.icb_rsp_err;   assign re[2]  = i2.icb_rsp_err;
  assign rdt[0] = i0.icb_rsp_rdata; assign rdt[1] = i1.icb_rsp_rdata; assign rdt[2] = i2.icb_rsp_rdata;
  assign ec[0]  = ec0; assign ec[1] = ec1; assign ec[2] = {14'd0, ec2};

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  bit   seen [3];
  bit   stall [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  function automatic int lat(input int id);
    case (id)
      0: return 1;
      1: return 3;
      default: return 1;
    endcase
  endfunction

  // Reference policy, written from the per-instance parameter choices above.
  function automatic exp_t model(input int id, input logic [31:0] a, input logic r,
                                 input int due, input bit exact);
    exp_t e;
    logic [31:0] rv_val;
    case (id)
      0: begin e.err = 1'b0;           rv_val = 32'hDEAD_BEEF; end
      1: begin e.err = !r;             rv_val = 32'h1234_5678; end
      default: begin e.err = (a[1:0] != 2'b00); rv_val = 32'hCAFE_F00D; end
    endcase
    e.rdata = (r && !e.err) ? rv_val : 32'h0;
    e.due   = due;
    e.exact = exact;
    return e;
  endfunction

  task automatic push_exp(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int q_size(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_head(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int id);
    case (id)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Monitor: compares the presented response against the queue head every cycle it is valid.
  always @(negedge clk) begin
    exp_t h;
    for (int i = 0; i < 3; i++) begin
      if (!rv[i]) begin
        chk($sformatf("idle_zero%0d", i), 64'({re[i], rdt[i]}), 64'(0));
        if (stall[i]) chk($sformatf("valid_held%0d", i), 64'(rv[i]), 64'(1));
        stall[i] = 1'b0;
      end else if (q_size(i) == 0) begin
        chk($sformatf("unexpected_rsp%0d", i), 64'(rv[i]), 64'(0));
      end else begin
        h = q_head(i);
        if (!seen[i]) begin
          seen[i] = 1'b1;
          if (h.exact) chk($sformatf("latency%0d", i), 64'(cyc), 64'(h.due));
          else         chk($sformatf("not_early%0d", i), 64'(cyc >= h.due), 64'(1));
        end
        chk($sformatf("rsp_err%0d", i), 64'(re[i]), 64'(h.err));
        chk($sformatf("rsp_rdata%0d", i), 64'(rdt[i]), 64'(h.rdata));
        if (rr[i]) begin
          q_pop(i);
          seen[i]  = 1'b0;
          stall[i] = 1'b0;
        end else begin
          stall[i] = 1'b1;
        end
      end
    end
  end

  // Called just after a posedge; returns just after the posedge following the handshake.
  task automatic send(input int id, input logic [31:0] a, input logic r, input bit exact, input bit rnd);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    cv[id] = 1'b1; ad[id] = a; rd[id] = r; wd[id] = $urandom;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (cr[id]) begin
        push_exp(id, model(id, a, r, cyc + lat(id), exact));
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (rnd) rr[id] = 1'($urandom_range(0, 1));
      n++;
    end
    chk($sformatf("accept%0d", id), 64'(ok), 64'(1));
    cv[id] = 1'b0;
  endtask

  task automatic drain(input int id, input bit rnd);
    int n;
    n = 0;
    rr[id] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (n < 200) begin
      @(negedge clk); #1;
      if (q_size(id) == 0 && !rv[id]) break;
      @(posedge clk); #1;
      rr[id] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    chk($sformatf("drain%0d", id), 64'(q_size(id)), 64'(0));
    @(posedge clk); #1;
    rr[id] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] wrap_addr [10] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5,
                                  32'h6, 32'h8, 32'hB, 32'hC, 32'hF};
  int          sat_exp [5]    = '{1, 2, 3, 3, 3};

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      cv[i] = 1'b0; rd[i] = 1'b0; rr[i] = 1'b0; clr[i] = 1'b0;
      ad[i] = '0; wd[i] = '0; seen[i] = 1'b0; stall[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_cmd_ready%0d", i), 64'(cr[i]), 64'(1));
      chk($sformatf("reset_rsp_valid%0d", i), 64'(rv[i]), 64'(0));
      chk($sformatf("reset_err_cnt%0d", i), 64'(ec[i]), 64'(0));
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read then write, LAT=1, response consumed immediately.
    rr[0] = 1'b1;
    send(0, 32'h100, 1'b1, 1'b1, 1'b0);
    send(0, 32'h104, 1'b0, 1'b1, 1'b0);
    drain(0, 1'b0);
    @(negedge clk);
    chk("u0_err_cnt", 64'(ec[0]), 64'(0));
    @(posedge clk); #1;

    // Back-to-back R,W,R,W at LAT=3, writes error.
    rr[1] = 1'b1;
    send(1, 32'h0, 1'b1, 1'b1, 1'b0);
    send(1, 32'h4, 1'b0, 1'b1, 1'b0);
    send(1, 32'h8, 1'b1, 1'b1, 1'b0);
    send(1, 32'hC, 1'b0, 1'b1, 1'b0);
    drain(1, 1'b0);
    @(negedge clk);
    chk("u1_err_cnt", 64'(ec[1]), 64'(2));
    @(posedge clk); #1;

    // Fill DEPTH=2 with rsp_ready low, then a one-cycle pop with same-cycle push.
    rr[0] = 1'b0;
    send(0, 32'h200, 1'b1, 1'b0, 1'b0);
    send(0, 32'h204, 1'b0, 1'b0, 1'b0);
    cv[0] = 1'b1; ad[0] = 32'h208; rd[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_ready", 64'(cr[0]), 64'(0));
      @(posedge clk); #1;
    end
    rr[0] = 1'b1;
    @(negedge clk);
    chk("passthru_ready", 64'(cr[0]), 64'(1));
    if (cr[0]) push_exp(0, model(0, 32'h208, 1'b1, cyc + 1, 1'b0));
    @(posedge clk); #1;
    rr[0] = 1'b0; ad[0] = 32'h20C;
    @(negedge clk);
    chk("occupancy_kept", 64'(cr[0]), 64'(0));
    @(posedge clk); #1;
    cv[0] = 1'b0;
    drain(0, 1'b0);

    // DEPTH=3 pointer wrap with random rsp_ready; 6 misaligned addresses saturate CW=2.
    rr[2] = 1'b1;
    for (int k = 0; k < 10; k++) send(2, wrap_addr[k], 1'(k % 2), 1'b0, 1'b1);
    drain(2, 1'b1);
    @(negedge clk);
    chk("u2_err_cnt_sat", 64'(ec[2]), 64'(3));
    @(posedge clk); #1;

    clr[2] = 1'b1;
    @(posedge clk); #1;
    clr[2] = 1'b0;
    @(negedge clk);
    chk("err_cnt_clr", 64'(ec[2]), 64'(0));
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      send(2, 32'h13 + 32'(k * 4), 1'(k % 2), 1'b0, 1'b0);
      drain(2, 1'b0);
      @(negedge clk);
      chk($sformatf("err_cnt_step%0d", k), 64'(ec[2]), 64'(sat_exp[k]));
      @(posedge clk); #1;
    end

    // Clear in the same cycle as the sixth errored pop: clear wins.
    rr[2] = 1'b0;
    send(2, 32'h33, 1'b1, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!rv[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sixth_rsp_seen", 64'(rv[2]), 64'(1));
    @(posedge clk); #1;
    rr[2] = 1'b1; clr[2] = 1'b1;
    @(posedge clk); #1;
    clr[2] = 1'b0;
    @(negedge clk);
    chk("clr_priority", 64'(ec[2]), 64'(0));
    chk("sixth_popped", 64'(q_size(2)), 64'(0));
    @(posedge clk); #1;

    // Asynchronous reset with two entries outstanding on the LAT=3 instance.
    rr[1] = 1'b0;
    send(1, 32'h10, 1'b1, 1'b0, 1'b0);
    send(1, 32'h14, 1'b1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", 64'(rv[1]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 64'(rv[1]), 64'(0));
    chk("async_cmd_ready", 64'(cr[1]), 64'(1));
    chk("async_err_cnt", 64'(ec[1]), 64'(0));
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; stall[i] = 1'b0; end
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rr[1] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_reset_ready", 64'(cr[1]), 64'(1));
    for (int i = 0; i < 3; i++) chk($sformatf("final_empty%0d", i), 64'(q_size(i)), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hicore_icb_err_slave.md
Name: hicore_icb_err_slave

Overview:
- Parametrised ICB default slave. It terminates every command with a configurable response latency, outstanding depth, error policy and read-data pattern.
- It sits on the unmapped and reserved decode legs of the ICB fabric, where it replaces the fixed one-deep zero-response slave.
- It provides back-pressure-correct buffering and a saturating error counter for debug.

Parameters:
- AW, 32, command address width.
- DW, 32, data width. DW must be a multiple of 8.
- DEPTH, 2, number of outstanding accepted-but-unresponded commands. Range 1..8.
- LAT, 1, minimum cycles from command handshake to rsp_valid. Range 1..15.
- ERR_MODE, 0, error policy: 0 = never err; 1 = always err; 2 = err on writes only; 3 = err when addr[1:0] != 0.
- RDATA_VAL, 0, DW-bit constant returned on non-error reads.
- CW, 16, width of the error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- icb_cmd_valid  in  1  command valid.
- icb_cmd_ready  out  1  command ready.
- icb_cmd_addr  in  AW  command address.
- icb_cmd_read  in  1  1 = read, 0 = write.
- icb_cmd_wdata  in  DW  write data. Ignored.
- icb_cmd_wmask  in  DW/8  write byte mask. Ignored.
- icb_rsp_valid  out  1  response valid.
- icb_rsp_ready  in  1  response ready.
- icb_rsp_err  out  1  response error flag.
- icb_rsp_rdata  out  DW  response read data.
- err_cnt  out  CW  saturating count of error responses delivered.
- err_cnt_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, all countdowns 0, err_cnt 0. Outputs during and after reset: icb_rsp_valid 0, icb_rsp_err 0, icb_rsp_rdata 0, icb_cmd_ready 1 (FIFO empty).
- Command handshake: occurs when icb_cmd_valid && icb_cmd_ready. On handshake, the slave pushes an entry {err, is_read, cnt = LAT-1} into a circular FIFO of DEPTH entries.
  - Pointers have log2 width plus one wrap bit, so full and empty are distinguished.
  - err is computed from ERR_MODE at accept time.
- Countdown: every cycle, each valid entry with cnt != 0 decrements by 1.
- Response valid: icb_rsp_valid = FIFO not empty && head.cnt == 0. All entries age identically, so the head always matures first and responses are in order.
- Latency: a command accepted in cycle t gives rsp_valid in cycle t+LAT at the earliest. With LAT=1 and the response consumed each cycle, throughput is one transaction per cycle.
- Response data:
  - icb_rsp_err = head.err.
  - icb_rsp_rdata = RDATA_VAL when head.is_read && !head.err; otherwise 0.
  - Both are zero whenever icb_rsp_valid = 0.
- Response stability: while icb_rsp_valid && !icb_rsp_ready, valid, err and rdata are held stable.
- Pop: occurs on icb_rsp_valid && icb_rsp_ready.
- icb_cmd_ready = !full || pop. When full, a pop and a push in the same cycle are both allowed (same-cycle pass-through of a slot). This is a combinational ready-from-rsp_ready path by design. The push into the freed slot must not overwrite the head until the head is popped.
- Simultaneous push and pop with the FIFO non-full: occupancy is unchanged and both pointers advance.
- Pointer wrap-around: pointers wrap modulo DEPTH. Non-power-of-two DEPTH must be handled with explicit compare-and-reset, not bit truncation.
- err_cnt:
  - Increments by 1 on each pop with err=1.
  - Saturates at 2^CW-1.
  - err_cnt_clr forces 0 and has priority over a same-cycle increment.
- icb_cmd_wdata and icb_cmd_wmask have no effect. Address bits beyond [1:0] have no effect.
- Mid-operation reset: all outstanding entries are discarded. No response is issued for commands accepted before reset.

Test Plan:
- LAT=1, DEPTH=2, ERR_MODE=0, RDATA_VAL=32'hDEAD_BEEF: a single read at addr 0x100 with rsp_ready=1 -> rsp_valid one cycle after the handshake, rdata=0xDEADBEEF, err=0; then a write -> rsp_valid, rdata=0, err=0.
- LAT=3, DEPTH=4, ERR_MODE=2: back-to-back R, W, R, W with rsp_ready=1 -> responses at cycles t+3..t+6, in order, err pattern 0,1,0,1; err_cnt ends at 2.
- DEPTH=2, rsp_ready held 0, cmd_valid held 1 -> exactly 2 handshakes, then cmd_ready=0. Raise rsp_ready for 1 cycle -> one pop and a same-cycle push; occupancy stays 2; rsp data does not change while stalled.
- DEPTH=3, LAT=1, ERR_MODE=3: 10 transactions to addr 0x0, 0x1, 0x2, 0x4, ... with random rsp_ready -> pointers wrap correctly, errs only on addr[1:0]!=0, no loss or duplication (scoreboard).
- CW=2, ERR_MODE=1: 5 errored responses -> err_cnt = 1, 2, 3, 3, 3. Assert err_cnt_clr in the same cycle as a 6th pop -> err_cnt=0.
- LAT=2: assert rst_n low while 2 entries are outstanding -> rsp_valid=0 immediately (asynchronous); after release, cmd_ready=1 and no stale responses appear.
